serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 39 +++
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result stream bundle for the bit-serial adder.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface serial_adder_ctrl_if #(
  parameter int NBITS = 8
);
  logic             istream_val;
  logic             istream_rdy;
  logic [NBITS-1:0] in0;
  logic [NBITS-1:0] in1;
  logic             cin;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [NBITS-1:0] sum;
  logic             cout;

  modport slave (
    input  istream_val,
    input  in0,
    input  in1,
    input  cin,
    input  ostream_rdy,
    output istream_rdy,
    output ostream_val,
    output sum,
    output cout
  );

  modport master (
    output istream_val,
    output in0,
    output in1,
    output cin,
    output ostream_rdy,
    input  istream_rdy,
    input  ostream_val,
    input  sum,
    input  cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder reused LSB first, one bit per cycle,
// wrapped in a valid/ready operand stream and a valid/ready result stream.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
  parameter int NBITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(NBITS) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] op_a;
  logic [NBITS-1:0] op_b;
  logic [NBITS-1:0] acc;
  logic [NBITS-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             in_rdy;
  logic             out_val;
  logic [CNT_W-1:0] count;

  logic             fa_sum;
  logic             fa_carry;
  logic [NBITS:0]   acc_cat;
  logic [NBITS-1:0] acc_next;
  logic             last_bit;

  // Operands shift right each cycle, so bit 0 is always the bit selected by count.
  serial_adder_fa u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_carry)
  );

  assign acc_cat  = {fa_sum, acc};
  assign acc_next = acc_cat[NBITS:1];
  assign last_bit = (count == CNT_W'(NBITS - 1));

  // Result is copied into sum_r/cout_r only on the final bit so outputs stay stable between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      cout_r  <= 1'b0;
      count   <= '0;
      in_rdy  <= 1'b1;
      out_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.istream_val && in_rdy) begin
            op_a   <= bus.in0;
            op_b   <= bus.in1;
            carry  <= bus.cin;
            count  <= '0;
            in_rdy <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_carry;
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (last_bit) begin
            sum_r   <= acc_next;
            cout_r  <= fa_carry;
            out_val <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.ostream_rdy) begin
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          in_rdy  <= 1'b1;
          out_val <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.istream_rdy = in_rdy;
  assign bus.ostream_val = out_val;
  assign bus.sum         = sum_r;
  assign bus.cout        = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at NBITS=8: table of sums plus
// hand-written backpressure and mid-operation reset sequences.
module tb_serial_adder_ctrl;
  localparam int NBITS = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  serial_adder_ctrl_if #(.NBITS(NBITS)) bus ();

  serial_adder_ctrl #(.NBITS(NBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.in0         = a;
    bus.in1         = b;
    bus.cin         = c;
    bus.istream_val = 1'b1;
  endtask

  // Starts at a negedge with the DUT idle and ends at the negedge where it is idle again.
  task automatic runTxn(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] s, input logic co, input int hold,
                        output int riseCyc);
    int lat;
    applyStimulus(a, b, c);
    bus.ostream_rdy = (hold == 0);
    checkOutput("idle_istream_rdy", bus.istream_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    bus.istream_val = 1'b0;
    bus.in0         = 8'h11;
    bus.in1         = ~b;
    bus.cin         = ~c;
    checkOutput("calc_istream_rdy", bus.istream_rdy, 0);
    checkOutput("calc_ostream_val", bus.ostream_val, 0);
    lat = 0;
    while (!bus.ostream_val && lat < 4 * NBITS) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, NBITS);
    riseCyc = cyc;
    checkOutput("sum", bus.sum, s);
    checkOutput("cout", bus.cout, co);
    for (int i = 0; i < hold; i++) begin
      bus.istream_val = 1'b1;
      bus.in0         = 8'h33;
      bus.in1         = 8'h44;
      @(negedge clk);
      checkOutput("hold_ostream_val", bus.ostream_val, 1);
      checkOutput("hold_istream_rdy", bus.istream_rdy, 0);
      checkOutput("hold_sum", bus.sum, s);
      checkOutput("hold_cout", bus.cout, co);
    end
    bus.istream_val = 1'b0;
    bus.ostream_rdy = 1'b1;
    @(negedge clk);
    checkOutput("pulse_end_ostream_val", bus.ostream_val, 0);
    checkOutput("back_idle_istream_rdy", bus.istream_rdy, 1);
    checkOutput("sum_held_after", bus.sum, s);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   rise;
    int   prevRise;
    logic sawVal;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h5A, 8'h25, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

    checks          = 0;
    errors          = 0;
    cyc             = 0;
    prevRise        = 0;
    reset           = 1'b1;
    bus.istream_val = 1'b0;
    bus.in0         = 8'h00;
    bus.in1         = 8'h00;
    bus.cin         = 1'b0;
    bus.ostream_rdy = 1'b1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_istream_rdy", bus.istream_rdy, 1);
    checkOutput("reset_ostream_val", bus.ostream_val, 0);
    checkOutput("reset_sum", bus.sum, 0);
    checkOutput("reset_cout", bus.cout, 0);

    $display("[TB] table vectors, back-to-back");
    for (int i = 0; i < 8; i++) begin
      runTxn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, 0, rise);
      if (i > 0) checkOutput("b2b_spacing", rise - prevRise, NBITS + 2);
      prevRise = rise;
    end

    $display("[TB] backpressure");
    runTxn(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3, rise);

    $display("[TB] reset mid-operation");
    applyStimulus(8'hF0, 8'h0F, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.istream_val = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_istream_rdy", bus.istream_rdy, 1);
    checkOutput("midreset_ostream_val", bus.ostream_val, 0);
    checkOutput("midreset_sum", bus.sum, 0);
    checkOutput("midreset_cout", bus.cout, 0);
    sawVal = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.ostream_val) sawVal = 1'b1;
    end
    checkOutput("abort_no_result", sawVal, 0);
    runTxn(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, rise);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
